// File: rtl/spi_slave_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regfile_pkg
// Purpose  : Shared constants and types for the SPI register-file protocol
//            layer: default geometry, default device ID, FSM state encoding
//            and the position of the read/write flag in a command word.
// Revision : 1.0  initial release
// ============================================================================
package spi_slave_regfile_pkg;

  localparam int unsigned      c_DEF_WIDTH_LOG  = 4;
  localparam int unsigned      c_DEF_ADDR_WIDTH = 4;
  localparam logic [15:0]      c_DEF_DEVICE_ID  = 16'hA55A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // The read/write flag always sits in the MSB of a command word.
  function automatic int unsigned rw_bit(input int unsigned width_log);
    return (32'd1 << width_log) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regfile_mem
// Purpose  : N x W register array with two write ports. The SPI port wins a
//            same-address collision; writes to different addresses both land.
// Ports    : clk, rst            clock, async active-high reset
//            spi_we_i/waddr/wdata SPI-side write port (priority)
//            host_we_i/addr/wdata core-side write port
//            ptr_i / ptr_rdata_o  combinational read for the burst pointer
//            host_rdata_o         combinational read at host_addr_i
//            reg_q_o              flattened contents, reg i at [i*W +: W]
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_regfile_mem #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 spi_we_i,
  input  logic [ADDR_WIDTH-1:0]                spi_waddr_i,
  input  logic [WIDTH-1:0]                     spi_wdata_i,
  input  logic                                 host_we_i,
  input  logic [ADDR_WIDTH-1:0]                host_addr_i,
  input  logic [WIDTH-1:0]                     host_wdata_i,
  input  logic [ADDR_WIDTH-1:0]                ptr_i,
  output logic [WIDTH-1:0]                     ptr_rdata_o,
  output logic [WIDTH-1:0]                     host_rdata_o,
  output logic [(2**ADDR_WIDTH)*WIDTH-1:0]     reg_q_o
);

  localparam int unsigned c_N = 2**ADDR_WIDTH;

  logic [c_N*WIDTH-1:0] w_flat;

  for (genvar i = 0; i < c_N; i++) begin : g_reg
    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_q <= '0;
      end else if (spi_we_i && (spi_waddr_i == ADDR_WIDTH'(i))) begin
        word_q <= spi_wdata_i;
      end else if (host_we_i && (host_addr_i == ADDR_WIDTH'(i))) begin
        word_q <= host_wdata_i;
      end
    end

    assign w_flat[i*WIDTH +: WIDTH] = word_q;
  end

  assign ptr_rdata_o  = w_flat[ptr_i*WIDTH +: WIDTH];
  assign host_rdata_o = w_flat[host_addr_i*WIDTH +: WIDTH];
  assign reg_q_o      = w_flat;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regfile
// Purpose  : Command/data framing on top of an SPI slave word interface.
//            First word of each CS-low frame is a command (MSB = write flag,
//            low bits = start address); following words are burst data with
//            auto-incrementing, wrapping address.
// Ports    : clk, rst                   clock, async active-high reset
//            cs_i                       chip select, active low
//            spi_start_i / spi_finish_i word start / word received strobes
//            spi_dout_i / spi_din_o     received word / next transmit word
//            host_we_i/addr/wdata       core-side write port
//            host_rdata_o               combinational reg[host_addr_i]
//            reg_q_o                    flattened register contents
//            spi_wr_pulse_o/rd_pulse_o  one-cycle access strobes
//            spi_addr_o                 address of the flagged access
// Revision : 1.0  initial release
// ============================================================================
module spi_slave_regfile
  import spi_slave_regfile_pkg::*;
#(
  parameter int unsigned                         SPI_MAX_WIDTH_LOG = c_DEF_WIDTH_LOG,
  parameter int unsigned                         REG_ADDR_WIDTH    = c_DEF_ADDR_WIDTH,
  parameter logic [(2**SPI_MAX_WIDTH_LOG)-1:0]   DEVICE_ID         = c_DEF_DEVICE_ID
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cs_i,
  input  logic                                                  spi_start_i,
  input  logic                                                  spi_finish_i,
  input  logic [(2**SPI_MAX_WIDTH_LOG)-1:0]                     spi_dout_i,
  output logic [(2**SPI_MAX_WIDTH_LOG)-1:0]                     spi_din_o,
  input  logic                                                  host_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]                             host_addr_i,
  input  logic [(2**SPI_MAX_WIDTH_LOG)-1:0]                     host_wdata_i,
  output logic [(2**SPI_MAX_WIDTH_LOG)-1:0]                     host_rdata_o,
  output logic [(2**REG_ADDR_WIDTH)*(2**SPI_MAX_WIDTH_LOG)-1:0] reg_q_o,
  output logic                                                  spi_wr_pulse_o,
  output logic                                                  spi_rd_pulse_o,
  output logic [REG_ADDR_WIDTH-1:0]                             spi_addr_o
);

  localparam int unsigned c_W      = 2**SPI_MAX_WIDTH_LOG;
  localparam int unsigned c_RW_BIT = rw_bit(SPI_MAX_WIDTH_LOG);

  state_e                    state_q, state_d;
  logic                      rw_q, rw_d;
  logic [REG_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [c_W-1:0]            din_q, din_d;
  logic                      wr_pulse_q, wr_pulse_d;
  logic                      rd_pulse_q, rd_pulse_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      w_spi_we;
  logic [c_W-1:0]            w_ptr_rdata;

  // spi_start only marks the point from which din must be stable; since din
  // only changes a cycle after a word completes, it needs no handling here.
  logic w_unused;
  assign w_unused = ^{spi_start_i, spi_dout_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      din_q      <= '0;
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      din_q      <= din_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    wr_pulse_d = 1'b0;
    rd_pulse_d = 1'b0;
    addr_d     = addr_q;
    w_spi_we   = 1'b0;

    // Deselect overrides everything, including a word finishing this cycle.
    if (cs_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (spi_finish_i) begin
            rw_d    = spi_dout_i[c_RW_BIT];
            ptr_d   = spi_dout_i[REG_ADDR_WIDTH-1:0];
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (spi_finish_i) begin
            w_spi_we   = rw_q;
            wr_pulse_d = rw_q;
            rd_pulse_d = ~rw_q;
            addr_d     = ptr_q;
            ptr_d      = ptr_q + REG_ADDR_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Transmit word follows the registered state, so it settles one cycle after
  // each command/data word and reflects any write committed on that edge.
  always_comb begin
    din_d = DEVICE_ID;
    if (state_q == ST_DATA) begin
      din_d = rw_q ? '0 : w_ptr_rdata;
    end
  end

  spi_slave_regfile_mem #(
    .WIDTH      (c_W),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_mem (
    .clk          (clk),
    .rst          (rst),
    .spi_we_i     (w_spi_we),
    .spi_waddr_i  (ptr_q),
    .spi_wdata_i  (spi_dout_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .ptr_i        (ptr_q),
    .ptr_rdata_o  (w_ptr_rdata),
    .host_rdata_o (host_rdata_o),
    .reg_q_o      (reg_q_o)
  );

  assign spi_din_o      = din_q;
  assign spi_wr_pulse_o = wr_pulse_q;
  assign spi_rd_pulse_o = rd_pulse_q;
  assign spi_addr_o     = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_regfile
// Purpose  : Self-checking bench for spi_slave_regfile. A register-array model
//            with frame-level rules predicts transmit words, strobes and
//            register contents for directed and random frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_regfile;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b1;
  logic          spi_start = 1'b0;
  logic          spi_finish = 1'b0;
  logic [15:0]   spi_dout = '0;
  logic [15:0]   spi_din;
  logic          host_we = 1'b0;
  logic [3:0]    host_addr = '0;
  logic [15:0]   host_wdata = '0;
  logic [15:0]   host_rdata;
  logic [255:0]  reg_q;
  logic          wr_pulse;
  logic          rd_pulse;
  logic [3:0]    spi_addr;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mregs [16];
  logic [3:0]  mlast;
  logic [15:0] tx_words [8];
  logic [22:0] obs  [8];
  logic [22:0] expv [8];

  spi_slave_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .cs_i           (cs),
    .spi_start_i    (spi_start),
    .spi_finish_i   (spi_finish),
    .spi_dout_i     (spi_dout),
    .spi_din_o      (spi_din),
    .host_we_i      (host_we),
    .host_addr_i    (host_addr),
    .host_wdata_i   (host_wdata),
    .host_rdata_o   (host_rdata),
    .reg_q_o        (reg_q),
    .spi_wr_pulse_o (wr_pulse),
    .spi_rd_pulse_o (rd_pulse),
    .spi_addr_o     (spi_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[i*16 +: 16] = mregs[i];
    return f;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mlast = '0;
  endfunction

  // Expected {din seen at start, wr pulse, rd pulse, spi_addr, pulse still high
  // one cycle later} for word i of a frame whose first word is cmd.
  function automatic logic [22:0] model_word(input logic [15:0] cmd, input int i,
                                             input logic [15:0] data);
    logic [3:0] ad;
    if (i == 0) return {16'hA55A, 1'b0, 1'b0, mlast, 1'b0};
    ad    = cmd[3:0] + 4'(i - 1);
    mlast = ad;
    if (cmd[15]) begin
      mregs[ad] = data;
      return {16'h0000, 1'b1, 1'b0, ad, 1'b0};
    end
    return {mregs[ad], 1'b0, 1'b1, ad, 1'b0};
  endfunction

  // One SPI word: start strobe, a few shift cycles, finish strobe. Optionally
  // drives a host write and/or deselect in the finish cycle.
  task automatic spi_word(input logic [15:0] tx, input logic hwe, input logic [3:0] ha,
                          input logic [15:0] hd, input logic abort, output logic [22:0] o);
    logic [15:0] d;
    logic        w, r, late;
    logic [3:0]  a;
    @(negedge clk);
    spi_start = 1'b1;
    d = spi_din;
    @(negedge clk);
    spi_start = 1'b0;
    repeat (3) @(negedge clk);
    spi_dout   = tx;
    spi_finish = 1'b1;
    host_we    = hwe;
    host_addr  = ha;
    host_wdata = hd;
    if (abort) cs = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    host_we    = 1'b0;
    w = wr_pulse;
    r = rd_pulse;
    a = spi_addr;
    @(negedge clk);
    late = wr_pulse | rd_pulse;
    o = {d, w, r, a, late};
  endtask

  task automatic do_frame(input int n);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_word(tx_words[i], 1'b0, 4'h0, 16'h0, 1'b0, obs[i]);
      expv[i] = model_word(tx_words[0], i, tx_words[i]);
    end
    cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cs  = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_q, spi_din, wr_pulse, rd_pulse, spi_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state: reg_q=%h din=%h wr=%b rd=%b addr=%h, required all zero",
               reg_q, spi_din, wr_pulse, rd_pulse, spi_addr);
    end
    rst = 1'b0;
    cs  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({spi_din, wr_pulse, rd_pulse} !== {16'hA55A, 2'b00}) begin
      failures++;
      $display("FAIL reset_devid: din=%h wr=%b rd=%b, required din=a55a no pulses",
               spi_din, wr_pulse, rd_pulse);
    end
    cs = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_frame();
    tx_words[0] = 16'h8003;
    tx_words[1] = 16'h1234;
    tx_words[2] = 16'h5678;
    do_frame(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL write_frame word%0d: got {din,wr,rd,addr,late}=%h required %h",
                 i, obs[i], expv[i]);
      end
    end
    checks++;
    if ({reg_q[4*16 +: 16], reg_q[3*16 +: 16]} !== {16'h5678, 16'h1234}) begin
      failures++;
      $display("FAIL write_frame_regs: reg4,reg3=%h required 56781234",
               {reg_q[4*16 +: 16], reg_q[3*16 +: 16]});
    end
  endtask

  task automatic test_read_frame();
    tx_words[0] = 16'h0003;
    tx_words[1] = 16'hDEAD;
    tx_words[2] = 16'hBEEF;
    do_frame(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL read_frame word%0d: got {din,wr,rd,addr,late}=%h required %h",
                 i, obs[i], expv[i]);
      end
    end
    checks++;
    if ({obs[1][22:7], obs[2][22:7]} !== {16'h1234, 16'h5678}) begin
      failures++;
      $display("FAIL read_frame_data: din word1,word2=%h required 12345678",
               {obs[1][22:7], obs[2][22:7]});
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++;
      $display("FAIL read_frame_regs: reg_q=%h required %h", reg_q, model_flat());
    end
  endtask

  task automatic test_wrap();
    tx_words[0] = 16'h800F;
    for (int i = 1; i < 4; i++) tx_words[i] = 16'($urandom);
    do_frame(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL wrap word%0d: got {din,wr,rd,addr,late}=%h required %h",
                 i, obs[i], expv[i]);
      end
    end
    checks++;
    if ({reg_q[15*16 +: 16], reg_q[0 +: 16], reg_q[16 +: 16]} !==
        {tx_words[1], tx_words[2], tx_words[3]}) begin
      failures++;
      $display("FAIL wrap_regs: reg15,reg0,reg1=%h required %h",
               {reg_q[15*16 +: 16], reg_q[0 +: 16], reg_q[16 +: 16]},
               {tx_words[1], tx_words[2], tx_words[3]});
    end
  endtask

  task automatic test_random_frames();
    int          n;
    logic [3:0]  ra;
    for (int f = 0; f < 16; f++) begin
      n = int'($urandom_range(1, 5));
      tx_words[0] = 16'($urandom);
      for (int i = 1; i < n; i++) tx_words[i] = 16'($urandom);
      do_frame(n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          failures++;
          $display("FAIL random_frame%0d word%0d: got {din,wr,rd,addr,late}=%h required %h",
                   f, i, obs[i], expv[i]);
        end
      end
      checks++;
      if (reg_q !== model_flat()) begin
        failures++;
        $display("FAIL random_frame%0d_regs: reg_q=%h required %h", f, reg_q, model_flat());
      end
      // Host write between frames, then a host readback at a random address.
      host_addr  = 4'($urandom);
      host_wdata = 16'($urandom);
      host_we    = 1'b1;
      mregs[host_addr] = host_wdata;
      @(negedge clk);
      host_we = 1'b0;
      ra = 4'($urandom);
      host_addr = ra;
      #1;
      checks++;
      if (host_rdata !== mregs[ra]) begin
        failures++;
        $display("FAIL host_rdata addr%0d: got %h required %h", ra, host_rdata, mregs[ra]);
      end
    end
  endtask

  task automatic test_collision();
    logic [15:0] hv;
    // SPI and host write the same address in the same cycle: SPI wins.
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_word(16'h8005, 1'b0, 4'h0, 16'h0, 1'b0, obs[0]);
    expv[0] = model_word(16'h8005, 0, 16'h8005);
    spi_word(16'h0001, 1'b1, 4'h5, 16'hFFFF, 1'b0, obs[1]);
    expv[1] = model_word(16'h8005, 1, 16'h0001);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL collision_same word%0d: got %h required %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if (reg_q[5*16 +: 16] !== 16'h0001) begin
      failures++;
      $display("FAIL collision_same_reg5: got %h required 0001", reg_q[5*16 +: 16]);
    end
    // Host writes a different address in the SPI write cycle: both commit.
    hv = 16'($urandom);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_word(16'h8005, 1'b0, 4'h0, 16'h0, 1'b0, obs[0]);
    expv[0] = model_word(16'h8005, 0, 16'h8005);
    spi_word(16'h0002, 1'b1, 4'h6, hv, 1'b0, obs[1]);
    expv[1] = model_word(16'h8005, 1, 16'h0002);
    mregs[6] = hv;
    cs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL collision_diff word%0d: got %h required %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if ({reg_q[5*16 +: 16], reg_q[6*16 +: 16]} !== {16'h0002, hv}) begin
      failures++;
      $display("FAIL collision_diff_regs: reg5,reg6=%h required %h",
               {reg_q[5*16 +: 16], reg_q[6*16 +: 16]}, {16'h0002, hv});
    end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    // Deselect in the finish cycle of a data word: word dropped.
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_word(16'h8009, 1'b0, 4'h0, 16'h0, 1'b0, obs[0]);
    expv[0] = model_word(16'h8009, 0, 16'h8009);
    spi_word(16'h1111, 1'b0, 4'h0, 16'h0, 1'b1, obs[1]);
    expv[1] = {16'h0000, 1'b0, 1'b0, mlast, 1'b0};
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL abort word%0d: got %h required %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if ({reg_q, spi_din} !== {model_flat(), 16'hA55A}) begin
      failures++;
      $display("FAIL abort_state: reg_q=%h din=%h required %h din=a55a",
               reg_q, spi_din, model_flat());
    end
    // Next frame's first word is a command again.
    tx_words[0] = 16'h8007;
    tx_words[1] = 16'($urandom);
    do_frame(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL abort_next word%0d: got %h required %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++;
      $display("FAIL abort_next_regs: reg_q=%h required %h", reg_q, model_flat());
    end
    // Reset in the middle of a burst with cs held low.
    d = 16'($urandom) | 16'h0001;
    cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_word(16'h8000, 1'b0, 4'h0, 16'h0, 1'b0, obs[0]);
    expv[0] = model_word(16'h8000, 0, 16'h8000);
    spi_word(d, 1'b0, 4'h0, 16'h0, 1'b0, obs[1]);
    expv[1] = model_word(16'h8000, 1, d);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({reg_q, spi_din, wr_pulse, rd_pulse, spi_addr} !== '0) begin
      failures++;
      $display("FAIL midburst_reset: reg_q=%h din=%h wr=%b rd=%b addr=%h, required all zero",
               reg_q, spi_din, wr_pulse, rd_pulse, spi_addr);
    end
    rst = 1'b0;
    model_clear();
    spi_word(16'h8002, 1'b0, 4'h0, 16'h0, 1'b0, obs[2]);
    expv[2] = model_word(16'h8002, 0, 16'h8002);
    spi_word(d, 1'b0, 4'h0, 16'h0, 1'b0, obs[3]);
    expv[3] = model_word(16'h8002, 1, d);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL midburst word%0d: got %h required %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if (reg_q !== model_flat()) begin
      failures++;
      $display("FAIL midburst_regs: reg_q=%h required %h", reg_q, model_flat());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_frame();
    test_read_frame();
    test_wrap();
    test_collision();
    test_abort();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- Register-bank protocol layer directly downstream of the SPI slave interface: consumes each received word (dout at spi_finish), supplies the next transmit word (din before spi_start).
- Implements a command/data framing per CS-low transaction with burst auto-increment, and exposes the register contents plus a host-side write port to the core.

Parameters:
SPI_MAX_WIDTH_LOG, 4, log2 of SPI word width W = 2**SPI_MAX_WIDTH_LOG (16 bits)
REG_ADDR_WIDTH, 4, register address width; N = 2**REG_ADDR_WIDTH registers of W bits
DEVICE_ID, 16'hA55A, W-bit word presented on din while waiting for a command

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous reset, active-high
cs  input  1  SPI chip select (active low), same signal fed to the SPI slave interface
spi_start  input  1  one-cycle pulse: word shift begins; din must be stable from here to spi_finish
spi_finish  input  1  one-cycle pulse: received word valid on spi_dout
spi_dout  input  W  received word from the SPI slave interface
spi_din  output  W  transmit word to the SPI slave interface
host_we  input  1  core-side write enable
host_addr  input  REG_ADDR_WIDTH  core-side write/read address
host_wdata  input  W  core-side write data
host_rdata  output  W  combinational reg[host_addr]
reg_q  output  N*W  flattened register contents, reg i at bits [i*W +: W]
spi_wr_pulse  output  1  one-cycle pulse on each SPI register write
spi_rd_pulse  output  1  one-cycle pulse on each completed SPI register read
spi_addr  output  REG_ADDR_WIDTH  address of the access flagged by spi_wr_pulse/spi_rd_pulse

Behaviour:
- Reset: all registers 0, FSM IDLE, ptr 0, rw 0, spi_din 0, spi_wr_pulse 0, spi_rd_pulse 0, spi_addr 0.
- Command word format: bit W-1 = rw (1 write, 0 read); bits [REG_ADDR_WIDTH-1:0] = start address; other bits ignored.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD when cs = 0.
  - CMD, spi_finish: rw <= spi_dout[W-1], ptr <= address field, -> DATA.
  - DATA, spi_finish, rw = 1: reg[ptr] <= spi_dout; spi_wr_pulse = 1 and spi_addr = ptr next cycle; ptr <= ptr+1 (wraps N-1 -> 0).
  - DATA, spi_finish, rw = 0: spi_rd_pulse = 1 and spi_addr = ptr next cycle; ptr <= ptr+1 (wraps).
  - Any state, cs = 1: -> IDLE next cycle. Takes priority over a same-cycle spi_finish, which is discarded. Partial words are dropped; no register change.
- spi_din is registered, updated every cycle:
  - DEVICE_ID in IDLE and CMD.
  - In DATA: reg[ptr] (the value after any write in the previous cycle) when rw = 0; 0 when rw = 1.
  - Latency: one cycle after a ptr/state change. The upstream stage guarantees at least 2 clk cycles between spi_finish and the next spi_start.
- Effect on the wire: the read response lags the command by one word. Word 1 of a read frame returns reg[addr], word 2 returns reg[addr+1], etc.
- Host port: host_we writes reg[host_addr] <= host_wdata. Same-cycle, same-address collision with an SPI write: SPI wins and the host write is lost; different addresses both commit.
- host_rdata and reg_q reflect register state after the clock edge (no extra latency).
- rst mid-frame: immediate return to reset values regardless of cs. If cs is still low after rst deasserts, the FSM enters CMD and treats the next word as a command.
- Pulses are exactly one cycle, never back-to-back in one frame, given the spacing guarantee above.

Decomposition:
- Shared package: command bit position (RW_BIT = W-1), state encoding (IDLE/CMD/DATA), DEVICE_ID default.
- One natural sub-module: spi_regfile_mem, the N x W register array with two write ports (SPI priority), combinational read mux for ptr and host_addr, and the flattened reg_q. FSM, ptr and spi_din logic stay in the top.

Test Plan:
- Reset then cs low: spi_din = 16'hA55A within 2 cycles; reg_q all 0; no pulses.
- Write frame cs low, words 16'h8003, 16'h1234, 16'h5678: reg3 = 16'h1234, reg4 = 16'h5678; spi_wr_pulse twice, with spi_addr 3 then 4.
- Read frame cs low, words 16'h0003, dummy, dummy: spi_din = 16'h1234 for word 1 and 16'h5678 for word 2; spi_rd_pulse with spi_addr 3, 4.
- Burst wrap: write command 16'h800F, then 3 data words A, B, C: reg15 = A, reg0 = B, reg1 = C.
- Collision: host_we to addr 5 (16'hFFFF) in the same cycle as an SPI write of 16'h0001 to addr 5 -> reg5 = 16'h0001. Host write to addr 6 in that cycle -> reg6 = host value.
- Abort: cs high asserted in the same cycle as spi_finish of a data word -> no write; FSM IDLE; the next frame's first word is decoded as a command. Also assert rst mid-burst -> all registers 0.
